// File: rtl/sample_uart_pkg.sv
// Shared types and byte constants for the UART sample receiver.
// Holds the frame parser state enum and the frame sync/channel bytes.
package sample_uart_pkg;

  typedef enum logic [2:0] {
    SYNC0,
    SYNC1,
    CH_ID,
    MSB,
    LSB
  } parse_st_t;

  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_H = 8'h48;
  localparam logic [7:0] ASCII_0 = 8'h30;

  function automatic logic is_ch_id(
    input logic [7:0] b
  );
    return b[7:2] == ASCII_0[7:2];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop sync, glitch-rejecting start, 8N1 framing.
// Ports: clk, rst, rx -> byte_valid, byte_data, stop_err (1-cycle pulses).
module uart_rx #(
  parameter int CLKS_PER_BIT = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          sync1;
  logic          sync2;
  logic          rx_prev;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      st         <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      rx_prev    <= sync2;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync2)
            st <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // line went back high: a glitch, not a start bit
            st      <= sync2 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              st <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            st  <= ST_IDLE;
            if (sync2) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_sample_rx.sv
// Parses "CH<id><msb><lsb>" UART frames into four signed sample registers.
// Ports: clk, rst, rx -> sample_out0..3, sample_update, sample_ch, frame_err.
module uart_sample_rx
  import sample_uart_pkg::*;
#(
  parameter int W            = 16,
  parameter int CLK_FREQ     = 24_000_000,
  parameter int BAUD_RATE    = 1_000_000,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                sample_update,
  output logic [1:0]          sample_ch,
  output logic                frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        stop_err;

  parse_st_t   st;
  parse_st_t   st_n;
  logic [1:0]  ch;
  logic [7:0]  msb;
  logic [TW-1:0] to_cnt;
  logic        timeout;
  logic        err_n;
  logic        wr_n;
  logic        ch_ld;
  logic        msb_ld;
  logic signed [15:0] raw;
  logic signed [W-1:0] samp [4];

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_err  (stop_err)
  );

  assign timeout = (st != SYNC0) && !byte_valid
                && (to_cnt == TO_MAX);
  assign raw = {msb, byte_data};

  always_comb begin
    st_n   = st;
    err_n  = 1'b0;
    wr_n   = 1'b0;
    ch_ld  = 1'b0;
    msb_ld = 1'b0;
    if (stop_err || timeout) begin
      st_n  = SYNC0;
      err_n = 1'b1;
    end else if (byte_valid) begin
      unique case (st)
        SYNC0: begin
          if (byte_data == ASCII_C)
            st_n = SYNC1;
        end
        SYNC1: begin
          unique case (1'b1)
            byte_data == ASCII_H: st_n = CH_ID;
            byte_data == ASCII_C: st_n = SYNC1;
            default: begin
              st_n  = SYNC0;
              err_n = 1'b1;
            end
          endcase
        end
        CH_ID: begin
          unique case (1'b1)
            is_ch_id(byte_data): begin
              ch_ld = 1'b1;
              st_n  = MSB;
            end
            byte_data == ASCII_C: begin
              st_n  = SYNC1;
              err_n = 1'b1;
            end
            default: begin
              st_n  = SYNC0;
              err_n = 1'b1;
            end
          endcase
        end
        MSB: begin
          msb_ld = 1'b1;
          st_n   = LSB;
        end
        LSB: begin
          wr_n = 1'b1;
          st_n = SYNC0;
        end
        default: st_n = SYNC0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= SYNC0;
      ch            <= '0;
      msb           <= '0;
      to_cnt        <= '0;
      sample_update <= 1'b0;
      sample_ch     <= '0;
      frame_err     <= 1'b0;
      for (int i = 0; i < 4; i++)
        samp[i] <= '0;
    end else begin
      st            <= st_n;
      frame_err     <= err_n;
      sample_update <= wr_n;
      // counts idle time inside a frame only; saturates at the limit
      if (byte_valid || st == SYNC0)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;
      if (ch_ld)
        ch <= byte_data[1:0];
      if (msb_ld)
        msb <= byte_data;
      if (wr_n) begin
        samp[ch]  <= W'(raw);
        sample_ch <= ch;
      end
    end
  end

  assign sample_out0 = samp[0];
  assign sample_out1 = samp[1];
  assign sample_out2 = samp[2];
  assign sample_out3 = samp[3];

endmodule

// File: tb/tb_uart_sample_rx.sv
// Scoreboard bench for uart_sample_rx at 24 MHz / 1 Mbaud.
// Stimulus queues expected writes; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_sample_rx;

  localparam int CPB = 24;

  logic clk;
  logic rst;
  logic rx;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;
  logic signed [15:0] sample_out2;
  logic signed [15:0] sample_out3;
  logic sample_update;
  logic [1:0] sample_ch;
  logic frame_err;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] model [4];
  int total;
  int bad;
  int err_seen;
  int upd_seen;
  int err0;
  int upd0;

  uart_sample_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .sample_out0  (sample_out0),
    .sample_out1  (sample_out1),
    .sample_out2  (sample_out2),
    .sample_out3  (sample_out3),
    .sample_update(sample_update),
    .sample_ch    (sample_ch),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #20.833 clk = ~clk;

  task automatic check(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_err)
        err_seen++;
      if (sample_update) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          check("unexp_update", 16'(exp_q.size()), 16'd1);
        end else begin
          e = exp_q.pop_front();
          model[e.ch] = e.val;
          check("upd_ch", 16'(sample_ch), 16'(e.ch));
          check("upd_s0", sample_out0, model[0]);
          check("upd_s1", sample_out1, model[1]);
          check("upd_s2", sample_out2, model[2]);
          check("upd_s3", sample_out3, model[3]);
        end
      end
    end
  end

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input logic stop = 1'b1
  );
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_wait();
    end
    rx = stop;
    bit_wait();
    rx = 1'b1;
    bit_wait();
    bit_wait();
  endtask

  task automatic send_frame(
    input logic [1:0] ch,
    input logic [15:0] val
  );
    exp_q.push_back('{ch: ch, val: val});
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h30 + 8'(ch));
    send_byte(val[15:8]);
    send_byte(val[7:0]);
    repeat (4) @(posedge clk);
  endtask

  task automatic mark();
    err0 = err_seen;
    upd0 = upd_seen;
  endtask

  task automatic deltas(
    input string nm,
    input int e_err,
    input int e_upd
  );
    repeat (4) @(posedge clk);
    check({nm, "_err"}, 16'(err_seen - err0), 16'(e_err));
    check({nm, "_upd"}, 16'(upd_seen - upd0), 16'(e_upd));
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    check({nm, "_s0"}, sample_out0, 16'h0);
    check({nm, "_s1"}, sample_out1, 16'h0);
    check({nm, "_s2"}, sample_out2, 16'h0);
    check({nm, "_s3"}, sample_out3, 16'h0);
    check({nm, "_upd"}, 16'(sample_update), 16'h0);
    check({nm, "_ch"}, 16'(sample_ch), 16'h0);
    check({nm, "_ferr"}, 16'(frame_err), 16'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    err_seen = 0;
    upd_seen = 0;
    for (int i = 0; i < 4; i++)
      model[i] = '0;
    rst = 1'b1;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk);

    mark();
    send_frame(2'd2, 16'h1234);
    deltas("t1", 0, 1);
    check("t1_s2", sample_out2, 16'h1234);

    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h37);
    send_frame(2'd0, 16'hFFFF);
    deltas("t2", 1, 1);

    mark();
    exp_q.push_back('{ch: 2'd1, val: 16'h8000});
    send_byte(8'h43);
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h31);
    send_byte(8'h80);
    send_byte(8'h00);
    deltas("t3", 0, 1);

    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h33);
    send_byte(8'h11, 1'b0);
    deltas("t4a", 1, 0);
    mark();
    send_frame(2'd3, 16'h5A5A);
    deltas("t4b", 0, 1);

    mark();
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h33);
    send_byte(8'hAB);
    repeat (20) bit_wait();
    deltas("t5to", 1, 0);
    check("t5_s3", sample_out3, 16'h5A5A);

    mark();
    @(posedge clk);
    rx = 1'b0;
    #150;
    rx = 1'b1;
    repeat (5) bit_wait();
    deltas("t5gl", 0, 0);

    send_frame(2'd1, 16'h0100);
    check("t6_s1", sample_out1, 16'h0100);
    send_byte(8'h43);
    send_byte(8'h48);
    send_byte(8'h31);
    rx = 1'b0;
    repeat (CPB * 4) @(posedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    check_zero("t6rst");
    for (int i = 0; i < 4; i++)
      model[i] = '0;
    exp_q.delete();
    @(posedge clk);
    rst = 1'b0;
    bit_wait();
    bit_wait();
    mark();
    send_frame(2'd1, 16'h7FFF);
    deltas("t6", 0, 1);
    check("t6_s1b", sample_out1, 16'h7FFF);

    repeat (50) begin
      if (exp_q.size() != 0)
        @(posedge clk);
    end
    check("q_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
